// File: rtl/fifo_pop_ctrl.sv
// Read-side controller for a FIFO whose memory lives outside this block.
// Tracks occupancy, drives the read address, checks even parity on each
// word as it is popped and presents the payload through a registered
// valid/ready output stage. A push is the writer's notice that it has
// already stored a word in the memory at that edge.
module fifo_pop_ctrl #(
  parameter int FIFO_DEPTH = 4,
  parameter int DATA_WIDTH = 17,
  parameter int ADDR_WIDTH = $clog2(FIFO_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [DATA_WIDTH-1:0] pop_data_in,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  empty,
  output logic                  full,
  output logic [DATA_WIDTH-2:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_par_err,
  output logic [7:0]            err_cnt,
  output logic                  ovf
);

  localparam logic [ADDR_WIDTH:0]   DEPTH_C   = (ADDR_WIDTH + 1)'(FIFO_DEPTH);
  localparam logic [ADDR_WIDTH:0]   CNT_ONE   = (ADDR_WIDTH + 1)'(1);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(FIFO_DEPTH - 1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);

  // Even parity over the whole stored word: any odd number of ones is an error.
  function automatic logic parity_bad(input logic [DATA_WIDTH-1:0] word);
    return ^word;
  endfunction

  // Saturating 8-bit increment for the error counter.
  function automatic logic [7:0] sat_inc8(input logic [7:0] val);
    return (val == 8'hFF) ? val : val + 8'd1;
  endfunction

  logic pop;
  logic push_ok;
  logic word_bad;

  assign empty    = (count == '0);
  assign full     = (count == DEPTH_C);
  // Pop whenever there is a stored word and the output stage is free or
  // is being emptied at this very edge, giving one word per cycle.
  assign pop      = !empty && (!out_valid || out_ready);
  // A push into a full FIFO only lands if a pop frees a slot at the same edge.
  assign push_ok  = push && (!full || pop);
  assign word_bad = parity_bad(pop_data_in);

  // Occupancy: +1 on accepted push, -1 on pop, unchanged on both or neither.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else begin
      case ({push_ok, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // Read pointer advances on each pop and wraps for non-power-of-2 depths.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_addr <= '0;
    end else if (pop) begin
      rd_addr <= (rd_addr == LAST_ADDR) ? '0 : rd_addr + ADDR_ONE;
    end
  end

  // Output register: load on pop, drop valid after a transfer with no refill.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data    <= '0;
      out_par_err <= 1'b0;
      out_valid   <= 1'b0;
    end else if (pop) begin
      out_data    <= pop_data_in[DATA_WIDTH-2:0];
      out_par_err <= word_bad;
      out_valid   <= 1'b1;
    end else if (out_ready) begin
      out_valid   <= 1'b0;
    end
  end

  // Parity error tally, counted at pop time, saturating at 255.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt <= 8'd0;
    end else if (pop && word_bad) begin
      err_cnt <= sat_inc8(err_cnt);
    end
  end

  // Sticky overflow flag: a push was dropped because no slot was free.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf <= 1'b0;
    end else if (push && full && !pop) begin
      ovf <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fifo_pop_ctrl.sv
// Self-checking bench for fifo_pop_ctrl: a small memory model plays the
// writer side, a scoreboard queue holds expected output words and a
// monitor compares each transfer against it.
module tb_fifo_pop_ctrl;

  localparam int DEPTH = 4;
  localparam int DW    = 17;
  localparam int AW    = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          push;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] pop_data_in;
  logic [AW:0]   count;
  logic          empty;
  logic          full;
  logic [DW-2:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic          out_par_err;
  logic [7:0]    err_cnt;
  logic          ovf;

  logic [DW-1:0] push_data;
  logic [DW-1:0] mem [DEPTH];
  int            wr_ptr;
  logic          mem_we;

  int total = 0;
  int bad   = 0;
  int xfers = 0;
  logic [DW-1:0] sb [$];   // {expected parity error, expected payload}

  fifo_pop_ctrl #(.FIFO_DEPTH(DEPTH), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n), .push(push), .rd_addr(rd_addr),
    .pop_data_in(pop_data_in), .count(count), .empty(empty), .full(full),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_par_err(out_par_err), .err_cnt(err_cnt), .ovf(ovf)
  );

  always #5 clk = ~clk;

  // Writer model: it never overwrites an unread slot, so it only stores a
  // word when the FIFO has room or the output stage can take a word now.
  assign mem_we      = !full || !out_valid || out_ready;
  assign pop_data_in = mem[rd_addr];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= 0;
    end else if (push && mem_we) begin
      mem[wr_ptr] <= push_data;
      wr_ptr      <= (wr_ptr + 1) % DEPTH;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: every transfer is compared to the oldest expected word.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      xfers++;
      if (sb.size() == 0) begin
        chk("unexpected_xfer", {15'd0, out_par_err, out_data}, 32'hFFFF_FFFF);
      end else begin
        logic [DW-1:0] e;
        e = sb.pop_front();
        chk("xfer_data", {16'd0, out_data}, {16'd0, e[DW-2:0]});
        chk("xfer_par_err", {31'd0, out_par_err}, {31'd0, e[DW-1]});
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [DW-1:0] d);
    push      = 1'b1;
    push_data = d;
    #1;
    if (mem_we) sb.push_back({^d, d[DW-2:0]});
    step();
    push = 1'b0;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    out_ready = 1'b1;
    while ((out_valid || !empty) && n < budget) begin
      step();
      n++;
    end
    step();
    chk("drain_done", {31'd0, out_valid}, 32'd0);
    chk("drain_sb_empty", sb.size(), 0);
  endtask

  initial begin
    logic          wrapped;
    logic [AW-1:0] prev_addr;
    int            x0;

    rst_n = 1'b0; push = 1'b0; push_data = '0; out_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    #12;
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_rd_addr", rd_addr, 0);
    chk("rst_err_cnt", err_cnt, 0);
    chk("rst_ovf", ovf, 0);
    step();
    rst_n = 1'b1;
    step();

    // Single good word
    out_ready = 1'b1;
    push_word(17'h1_0001);
    chk("single_count_after_push", count, 1);
    chk("single_valid_latency", out_valid, 0);
    step();
    chk("single_valid", out_valid, 1);
    chk("single_data", out_data, 32'h0001);
    chk("single_par_err", out_par_err, 0);
    chk("single_count", count, 0);
    chk("single_rd_addr", rd_addr, 1);
    step();
    chk("single_valid_clear", out_valid, 0);

    // Parity error word
    push_word(17'h1_0003);
    step();
    chk("par_err_flag", out_par_err, 1);
    chk("par_err_cnt", err_cnt, 1);
    drain(10);

    // Fill and stall with DEPTH=4
    out_ready = 1'b0;
    push_word(17'h0_0011);
    chk("fill_count1", count, 1);
    push_word(17'h0_0022);
    chk("fill_valid", out_valid, 1);
    chk("fill_count_after2", count, 1);
    push_word(17'h0_0033);
    chk("stall_data_1", out_data, 32'h0011);
    push_word(17'h0_0044);
    chk("stall_data_2", out_data, 32'h0011);
    push_word(17'h0_0055);
    chk("stall_data_3", out_data, 32'h0011);
    chk("fill_count4", count, 4);
    chk("fill_full", full, 1);
    chk("fill_no_ovf_yet", ovf, 0);
    push_word(17'h0_0066);
    chk("ovf_set", ovf, 1);
    chk("ovf_count_held", count, 4);
    out_ready = 1'b1;
    step();
    chk("release_next_data", out_data, 32'h0022);
    chk("release_valid", out_valid, 1);
    chk("release_count", count, 3);
    drain(12);
    chk("ovf_sticky", ovf, 1);

    // Streaming ten words with out_ready held high
    x0 = xfers;
    wrapped = 1'b0;
    prev_addr = rd_addr;
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      push_word(17'(32'h0100 + i * 32'h0111));
      chk("stream_count_le1", {31'd0, (count <= 3'd1)}, 1);
      if (prev_addr == 2'd3 && rd_addr == 2'd0) wrapped = 1'b1;
      prev_addr = rd_addr;
    end
    drain(10);
    chk("stream_xfers", xfers - x0, 10);
    chk("stream_rd_addr_wrap", wrapped, 1);

    // Saturate the parity error counter
    for (int i = 0; i < 260; i++) push_word(17'h0_0001);
    drain(10);
    chk("err_cnt_sat", err_cnt, 255);

    // Asynchronous reset with three words stored
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) push_word(17'(32'h0A00 + i));
    chk("pre_rst_count", count, 3);
    chk("pre_rst_valid", out_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_count", count, 0);
    chk("arst_empty", empty, 1);
    chk("arst_valid", out_valid, 0);
    chk("arst_data", out_data, 0);
    chk("arst_rd_addr", rd_addr, 0);
    chk("arst_par_err", out_par_err, 0);
    chk("arst_err_cnt", err_cnt, 0);
    chk("arst_ovf", ovf, 0);
    sb.delete();
    step();
    rst_n = 1'b1;
    out_ready = 1'b1;
    step();
    step();
    chk("post_rst_idle_valid", out_valid, 0);
    chk("post_rst_empty", empty, 1);
    push_word(17'h0_0505);
    step();
    chk("post_rst_data", out_data, 32'h0505);
    drain(10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

endmodule

// File: doc/fifo_pop_ctrl.md
FIFO_POP_CTRL -- requirements
Module: fifo_pop_ctrl

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, number of FIFO entries (any value >= 2, not only powers of 2).
REQ-002 SHALL have parameter DATA_WIDTH, default 17, stored word width: payload in bits [DATA_WIDTH-2:0], parity in bit [DATA_WIDTH-1].
REQ-003 SHALL have parameter ADDR_WIDTH, default $clog2(FIFO_DEPTH), memory address width.
REQ-004 SHALL use one clock and an asynchronous, active-low reset.
REQ-005 clk  input  1  rising-edge clock for all state.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 push  input  1  the writer stored a word in the FIFO memory at this edge.
REQ-008 rd_addr  output  ADDR_WIDTH  read address to the FIFO memory.
REQ-009 pop_data_in  input  DATA_WIDTH  combinational memory read data at rd_addr.
REQ-010 count  output  ADDR_WIDTH+1  number of words stored and not yet popped.
REQ-011 empty / full  output  1 each  count==0 / count==FIFO_DEPTH.
REQ-012 out_data  output  DATA_WIDTH-1  registered payload.
REQ-013 out_valid / out_ready  output / input  1 each  output handshake; a transfer occurs when both are 1 at a rising edge.
REQ-014 out_par_err  output  1  the word in out_data failed parity.
REQ-015 err_cnt  output  8  saturating count of parity-failed words.
REQ-016 ovf  output  1  sticky: a push arrived while full.

Function
REQ-017 Parity check: even parity, so the word is good when the XOR of all DATA_WIDTH bits of pop_data_in is 0.
REQ-018 Pop condition: pop = !empty && (!out_valid || out_ready), evaluated on current-cycle state.
REQ-019 On pop, the block SHALL do all of the following at the same edge:
- load out_data with pop_data_in[DATA_WIDTH-2:0];
- load out_par_err with the parity result;
- set out_valid=1;
- advance rd_addr.
REQ-020 rd_addr SHALL wrap from FIFO_DEPTH-1 to 0.
REQ-021 If out_valid && out_ready && !pop, out_valid SHALL clear next edge; otherwise out_valid and out_data hold while out_ready=0.
REQ-022 Count update:
- push without pop: count+1;
- pop without push: count-1;
- push and pop together: count unchanged.
REQ-023 A push while full and without a same-cycle pop SHALL be ignored (count unchanged) and SHALL set ovf; a push while full with a same-cycle pop is legal.
REQ-024 A word pushed at edge N SHALL be poppable at edge N+1 earliest, so out_valid rises one cycle after push when the FIFO and output register are empty.
REQ-025 With out_ready held 1, the block SHALL sustain one word per cycle.
REQ-026 err_cnt SHALL increment on each pop with a parity failure and SHALL saturate at 255.
REQ-027 empty and full SHALL be combinational decodes of count only.

Reset
REQ-028 On rst_n=0, all of the following SHALL be 0 immediately, regardless of clk:
- rd_addr, count, out_valid, out_data;
- out_par_err, err_cnt, ovf.
REQ-029 Reset mid-transfer SHALL discard the stored and registered words; after release, empty=1 and nothing is output until a new push.

Verification
REQ-030 Single word: push 17'h1_0001 (good) into an empty FIFO, out_ready=1 -> next edge out_valid=1, out_data=16'h0001, out_par_err=0, count=0, rd_addr=1.
REQ-031 Parity error: push 17'h1_0003 -> out_par_err=1, err_cnt=1; 256 bad words -> err_cnt=255.
REQ-032 Fill and stall: out_ready=0, push 5 words with DEPTH=4 -> one pops into the output register, count reaches 4, full=1, next push sets ovf=1, count stays 4.
REQ-033 Streaming: push every cycle with out_ready=1 for 10 cycles -> 10 transfers in order, count<=1, rd_addr wraps 3->0.
REQ-034 Backpressure: out_valid=1, out_ready=0 for 3 cycles -> out_data stable; release -> transfer, and the next word loads at the same edge.
REQ-035 Async reset: assert rst_n=0 between edges with count=3 -> outputs 0 before the next edge, empty=1.
